// File: rtl/i2c_write_sequencer.sv
// rtl/i2c_write_sequencer.sv - single-byte I2C master write sequencer (address + one data byte)
//
// Purpose: on Start, issues START, {SlaveAddr,W}, checks ACK, WriteData, checks ACK, STOP.
// Bit timing is built from four quarters (q0..q3) of QTR clk cycles each.
//
// Ports:
//   clk               - single clock, rising edge
//   Reset             - asynchronous active-low reset
//   Start             - transaction request, only looked at while idle
//   SlaveAddr[6:0]    - target address, captured when Start is accepted
//   WriteData[7:0]    - data byte, captured when Start is accepted
//   SDA_in            - sampled bus SDA, used in the ACK slots
//   EightBitCount[31:0] - value of the external bit counter
//   LoadEightBitCount - pulse: load external counter with 8 (first cycle of ADDR/DATA)
//   DecEightBitCount  - pulse: decrement external counter (last cycle of each bit)
//   SCL               - bus clock, 1 = released
//   SDA_oe            - open-drain SDA, 1 = pull low
//   Busy              - transaction in progress
//   Done              - one-cycle completion pulse
//   AckError          - a NACK was seen; cleared by the next accepted Start
module i2c_write_sequencer #(
  parameter int QTR = 2
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [6:0]  SlaveAddr,
  input  logic [7:0]  WriteData,
  input  logic        SDA_in,
  input  logic [31:0] EightBitCount,
  output logic        LoadEightBitCount,
  output logic        DecEightBitCount,
  output logic        SCL,
  output logic        SDA_oe,
  output logic        Busy,
  output logic        Done,
  output logic        AckError
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP
  } state_t;

  localparam logic [7:0] TMR_LAST = 8'(QTR - 1);

  state_t     state_q, state_d;
  logic [7:0] tmr_q, tmr_d;
  logic [1:0] qtr_q, qtr_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] data_q, data_d;
  logic       ack_err_q, ack_err_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       scl_q, scl_d;
  logic       sda_oe_q, sda_oe_d;
  logic       load_q, load_d;
  logic       dec_q, dec_d;

  logic qtr_end;
  logic slot_end;
  logic ack_sample;

  assign qtr_end    = (tmr_q == TMR_LAST);
  assign slot_end   = qtr_end && (qtr_q == 2'd3);
  assign ack_sample = qtr_end && (qtr_q == 2'd2);

  // Next-state: state, quarter timer, shift register, operands, flags.
  always_comb begin
    state_d   = state_q;
    tmr_d     = 8'd0;
    qtr_d     = 2'd0;
    sh_d      = sh_q;
    data_d    = data_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;

    // Timer free-runs in every non-idle state; the 2-bit quarter index
    // wraps naturally at the end of a slot, so each new slot starts at q0/0.
    if (state_q != IDLE) begin
      tmr_d = qtr_end ? 8'd0 : tmr_q + 8'd1;
      qtr_d = qtr_end ? qtr_q + 2'd1 : qtr_q;
    end

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d   = START;
          sh_d      = {SlaveAddr, 1'b0};
          data_d    = WriteData;
          ack_err_d = 1'b0;
        end
      end
      START: begin
        if (slot_end) state_d = ADDR;
      end
      ADDR, DATA: begin
        if (slot_end) begin
          sh_d = {sh_q[6:0], 1'b0};
          // slot_end here is exactly the DecEightBitCount cycle; the external
          // counter still shows the pre-decrement value.
          if (EightBitCount == 32'd1) begin
            state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
          end
        end
      end
      ADDR_ACK: begin
        if (ack_sample && SDA_in) ack_err_d = 1'b1;
        if (slot_end) begin
          // ack_err_q was already updated at the end of q2 of this slot.
          if (ack_err_q) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
            sh_d    = data_q;
          end
        end
      end
      DATA_ACK: begin
        if (ack_sample && SDA_in) ack_err_d = 1'b1;
        if (slot_end) state_d = STOP;
      end
      STOP: begin
        if (slot_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next-state values and registered, so the
  // bus pins come straight from flops yet line up with the state they describe.
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    dec_d    = 1'b0;
    busy_d   = (state_d != IDLE);
    load_d   = ((state_d == ADDR) && (state_q == START)) ||
               ((state_d == DATA) && (state_q == ADDR_ACK));

    case (state_d)
      START: begin
        sda_oe_d = qtr_d[1];
      end
      ADDR, DATA: begin
        scl_d    = qtr_d[1];
        sda_oe_d = ~sh_d[7];
        dec_d    = (qtr_d == 2'd3) && (tmr_d == TMR_LAST);
      end
      ADDR_ACK, DATA_ACK: begin
        scl_d = qtr_d[1];
      end
      STOP: begin
        scl_d    = (qtr_d != 2'd0);
        sda_oe_d = ~qtr_d[1];
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      tmr_q     <= 8'd0;
      qtr_q     <= 2'd0;
      sh_q      <= 8'd0;
      data_q    <= 8'd0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      load_q    <= 1'b0;
      dec_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      qtr_q     <= qtr_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      load_q    <= load_d;
      dec_q     <= dec_d;
    end
  end

  assign LoadEightBitCount = load_q;
  assign DecEightBitCount  = dec_q;
  assign SCL               = scl_q;
  assign SDA_oe            = sda_oe_q;
  assign Busy              = busy_q;
  assign Done              = done_q;
  assign AckError          = ack_err_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// tb/tb_i2c_write_sequencer.sv - scoreboard bench for i2c_write_sequencer (QTR=1 and QTR=3 instances)
module tb_i2c_write_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset;
  logic        Start, Start3;
  logic [6:0]  SlaveAddr;
  logic [7:0]  WriteData;
  logic        nack_a, nack_d;
  logic        sda_in1, sda_in3;
  logic [31:0] cnt1, cnt3;
  int          ndec1;

  logic load1, dec1, scl1, sda_oe1, busy1, done1, aerr1;
  logic load3, dec3, scl3, sda_oe3, busy3, done3, aerr3;

  i2c_write_sequencer #(.QTR(1)) dut1 (
    .clk(clk), .Reset(Reset), .Start(Start), .SlaveAddr(SlaveAddr), .WriteData(WriteData),
    .SDA_in(sda_in1), .EightBitCount(cnt1), .LoadEightBitCount(load1), .DecEightBitCount(dec1),
    .SCL(scl1), .SDA_oe(sda_oe1), .Busy(busy1), .Done(done1), .AckError(aerr1)
  );

  i2c_write_sequencer #(.QTR(3)) dut3 (
    .clk(clk), .Reset(Reset), .Start(Start3), .SlaveAddr(SlaveAddr), .WriteData(WriteData),
    .SDA_in(sda_in3), .EightBitCount(cnt3), .LoadEightBitCount(load3), .DecEightBitCount(dec3),
    .SCL(scl3), .SDA_oe(sda_oe3), .Busy(busy3), .Done(done3), .AckError(aerr3)
  );

  // External bit counters and a slave that answers per ACK slot.
  always @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      cnt1  <= 32'd0;
      cnt3  <= 32'd0;
      ndec1 <= 0;
    end else begin
      if (load1) cnt1 <= 32'd8;
      else if (dec1) cnt1 <= cnt1 - 32'd1;
      if (load3) cnt3 <= 32'd8;
      else if (dec3) cnt3 <= cnt3 - 32'd1;
      if (!busy1) ndec1 <= 0;
      else if (dec1) ndec1 <= ndec1 + 1;
    end
  end

  assign sda_in1 = (ndec1 == 8) ? nack_a : ((ndec1 == 16) ? nack_d : 1'b1);

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int   dur;
    logic aerr;
  } done_exp_t;

  logic      bitq[$];
  done_exp_t doneq[$];

  // Scoreboard push + Start drive; called at a negedge, returns one negedge later.
  task automatic launch(input logic [6:0] a, input logic [7:0] d, input logic na, input logic nd);
    logic [7:0] ab;
    ab = {a, 1'b0};
    for (int i = 7; i >= 0; i--) bitq.push_back(ab[i]);
    bitq.push_back(1'b1);
    if (na) begin
      bitq.push_back(1'b0);
      doneq.push_back('{44, 1'b1});
    end else begin
      for (int i = 7; i >= 0; i--) bitq.push_back(d[i]);
      bitq.push_back(1'b1);
      bitq.push_back(1'b0);
      doneq.push_back('{80, nd});
    end
    SlaveAddr = a;
    WriteData = d;
    nack_a    = na;
    nack_d    = nd;
    Start     = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input int which, input int limit, input string tag);
    int n;
    logic dn;
    n  = 0;
    dn = (which == 1) ? done1 : done3;
    while (dn !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
      dn = (which == 1) ? done1 : done3;
    end
    check(tag, {31'd0, dn}, 32'd1);
  endtask

  // Monitor for the QTR=1 instance.
  int   cyc1 = 0;
  int   dones1 = 0;
  int   extra_bits = 0;
  int   extra_dones = 0;
  logic busy1_p = 1'b0;
  logic scl1_p = 1'b1;

  always @(negedge clk) begin
    logic      eb;
    done_exp_t e;
    if (busy1 && !busy1_p) cyc1 = 0;
    else cyc1++;
    if (busy1 && scl1 && !scl1_p) begin
      if (bitq.size() == 0) extra_bits++;
      else begin
        eb = bitq.pop_front();
        check("sda_bit", {31'd0, ~sda_oe1}, {31'd0, eb});
      end
    end
    if (load1 || dec1) check("load_dec_overlap", {31'd0, load1 & dec1}, 32'd0);
    if (done1) begin
      dones1++;
      check("busy_in_done", {31'd0, busy1}, 32'd0);
      if (doneq.size() == 0) extra_dones++;
      else begin
        e = doneq.pop_front();
        check("duration", cyc1, e.dur);
        check("ack_error", {31'd0, aerr1}, {31'd0, e.aerr});
      end
    end
    busy1_p = busy1;
    scl1_p  = scl1;
  end

  // Monitor for the QTR=3 instance: SCL phase lengths and pulse counts.
  int   cyc3 = 0, run3 = 0, ph3 = 0, ld3 = 0, dc3 = 0, dones3 = 0;
  logic busy3_p = 1'b0;
  logic scl3_p = 1'b1;
  logic tog3 = 1'b0;

  always @(negedge clk) begin
    if (busy3 && !busy3_p) begin
      cyc3 = 0; ld3 = 0; dc3 = 0; ph3 = 0; run3 = 0; tog3 = 1'b0;
    end else cyc3++;
    if (busy3) begin
      if (load3) ld3++;
      if (dec3) dc3++;
      if (scl3 != scl3_p) begin
        // The last completed phase is the STOP q0 low, one quarter long.
        if (tog3) begin
          check("q3_scl_phase", run3, (ph3 == 36) ? 3 : 6);
          ph3++;
        end
        tog3 = 1'b1;
        run3 = 1;
      end else run3++;
    end
    if (done3) begin
      dones3++;
      check("q3_duration", cyc3, 240);
      check("q3_loads", ld3, 2);
      check("q3_decs", dc3, 16);
      check("q3_phases", ph3, 37);
      check("q3_ack_error", {31'd0, aerr3}, 32'd0);
    end
    busy3_p = busy3;
    scl3_p  = scl3;
  end

  initial begin
    int d0;
    Reset = 1'b0; Start = 1'b0; Start3 = 1'b0; sda_in3 = 1'b0;
    SlaveAddr = 7'd0; WriteData = 8'd0; nack_a = 1'b0; nack_d = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_scl", {31'd0, scl1}, 32'd1);
    check("rst_sda_oe", {31'd0, sda_oe1}, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_ack_error", {31'd0, aerr1}, 32'd0);
    check("rst_load", {31'd0, load1}, 32'd0);
    check("rst_dec", {31'd0, dec1}, 32'd0);
    Reset = 1'b1;

    // QTR=3 transaction; Start raised right after reset release.
    SlaveAddr = 7'h50; WriteData = 8'hA5; Start3 = 1'b1;
    @(negedge clk);
    Start3 = 1'b0;
    check("q3_first_start", {31'd0, busy3}, 32'd1);
    wait_done(3, 400, "q3_done_seen");
    @(negedge clk);

    // Fully ACKed transfer, then Start in the Done cycle with an address NACK.
    launch(7'h50, 8'hA5, 1'b0, 1'b0);
    wait_done(1, 200, "ack_done_seen");
    launch(7'h50, 8'hA5, 1'b1, 1'b0);
    wait_done(1, 200, "nack_addr_done_seen");
    @(negedge clk);

    // NACK on data only; the next Start must clear AckError.
    launch(7'h3C, 8'h0F, 1'b0, 1'b1);
    wait_done(1, 200, "nack_data_done_seen");
    @(negedge clk);
    launch(7'h12, 8'h81, 1'b0, 1'b0);
    check("ack_error_cleared", {31'd0, aerr1}, 32'd0);
    wait_done(1, 200, "clear_done_seen");
    @(negedge clk);

    // Starts while busy at cycles 10 and 40 must be ignored.
    d0 = dones1;
    launch(7'h7F, 8'h00, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    SlaveAddr = 7'h01; WriteData = 8'hFF; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (29) @(negedge clk);
    SlaveAddr = 7'h2A; WriteData = 8'h5A; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_done(1, 200, "busy_start_done_seen");
    repeat (100) @(negedge clk);
    check("busy_start_one_done", dones1 - d0, 1);

    // Asynchronous reset inside DATA, then a clean transfer.
    launch(7'h55, 8'h33, 1'b0, 1'b0);
    repeat (49) @(negedge clk);
    #2 Reset = 1'b0;
    #1;
    check("abort_scl", {31'd0, scl1}, 32'd1);
    check("abort_sda_oe", {31'd0, sda_oe1}, 32'd0);
    check("abort_busy", {31'd0, busy1}, 32'd0);
    bitq.delete();
    doneq.delete();
    repeat (3) @(negedge clk);
    check("abort_no_done", {31'd0, done1}, 32'd0);
    Reset = 1'b1;
    launch(7'h21, 8'hC3, 1'b0, 1'b0);
    check("post_reset_first_start", {31'd0, busy1}, 32'd1);
    wait_done(1, 200, "post_reset_done_seen");
    repeat (5) @(negedge clk);

    check("extra_bits", extra_bits, 0);
    check("extra_dones", extra_dones, 0);
    check("bits_left", bitq.size(), 0);
    check("dones_left", doneq.size(), 0);
    check("dones_total", dones1, 6);
    check("q3_dones_total", dones3, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1);
  end

endmodule
